// File: rtl/fft_stream_pkg.sv
// rtl/fft_stream_pkg.sv - shared constants and FSM encodings for the FFT stream interface
package fft_stream_pkg;

  localparam int FFT_DW = 16;
  localparam int FFT_N  = 16;
  localparam int HALF   = 8;

  typedef enum logic [1:0] {
    IN_FILL = 2'd0,
    IN_FULL = 2'd1,
    IN_LOAD = 2'd2
  } in_state_e;

  typedef enum logic [1:0] {
    OUT_IDLE  = 2'd0,
    OUT_WAIT  = 2'd1,
    OUT_CAPT  = 2'd2,
    OUT_DRAIN = 2'd3
  } out_state_e;

endpackage

// File: rtl/fft_stream_if_frame_buf.sv
// rtl/fft_stream_if_frame_buf.sv - 16-slot frame register file, serial port plus pair port (slots j, j+8)
module frame_buf
  import fft_stream_pkg::*;
#(
  parameter int DW        = FFT_DW,
  parameter bit SERIAL_WR = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_we,
  input  logic [3:0]      i_ser_idx,
  input  logic [2*DW-1:0] i_ser_wdata,
  output logic [2*DW-1:0] o_ser_rdata,
  input  logic [2:0]      i_pair_idx,
  input  logic [2*DW-1:0] i_pair_wdata0,
  input  logic [2*DW-1:0] i_pair_wdata1,
  output logic [2*DW-1:0] o_pair_rdata0,
  output logic [2*DW-1:0] o_pair_rdata1
);

  logic [2*DW-1:0] r_mem [FFT_N];

  assign o_ser_rdata   = r_mem[i_ser_idx];
  assign o_pair_rdata0 = r_mem[{1'b0, i_pair_idx}];
  assign o_pair_rdata1 = r_mem[{1'b1, i_pair_idx}];

  // SERIAL_WR picks which side owns the write; the other side is read-only
  generate
    if (SERIAL_WR) begin : g_ser_wr
      logic w_unused;
      assign w_unused = ^{i_pair_wdata0, i_pair_wdata1};
      always_ff @(posedge i_clk) begin
        if (i_we) begin
          r_mem[i_ser_idx] <= i_ser_wdata;
        end
      end
    end else begin : g_pair_wr
      logic w_unused;
      assign w_unused = ^i_ser_wdata;
      always_ff @(posedge i_clk) begin
        if (i_we) begin
          r_mem[{1'b0, i_pair_idx}] <= i_pair_wdata0;
          r_mem[{1'b1, i_pair_idx}] <= i_pair_wdata1;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/fft_stream_if.sv
// rtl/fft_stream_if.sv - streams natural-order frames into lane pairs and collects lane-pair results back into a stream
module fft_stream_if
  import fft_stream_pkg::*;
#(
  parameter int DW = FFT_DW,
  parameter int N  = FFT_N
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            S_VALID,
  output logic            S_READY,
  input  logic [2*DW-1:0] S_DATA,
  output logic            START,
  output logic [2*DW-1:0] LANE0_OUT,
  output logic [2*DW-1:0] LANE1_OUT,
  input  logic            DONE,
  input  logic [2*DW-1:0] LANE0_IN,
  input  logic [2*DW-1:0] LANE1_IN,
  output logic            M_VALID,
  input  logic            M_READY,
  output logic [2*DW-1:0] M_DATA,
  output logic            ERR
);

  localparam int CW = $clog2(N);
  localparam int HW = $clog2(HALF);

  in_state_e       r_in_state, w_in_next;
  out_state_e      r_out_state, w_out_next;
  logic [CW-1:0]   r_icnt, r_ocnt;
  logic [HW-1:0]   r_lcnt, r_ccnt;
  logic            r_done_d, r_err;
  logic            w_s_fire, w_m_fire, w_start, w_done_rise, w_capt, w_err_set;
  logic [2*DW-1:0] w_ld0, w_ld1, w_drain_data;
  logic [2*DW-1:0] w_ibuf_ser, w_obuf_p0, w_obuf_p1;
  logic            w_unused;

  assign w_s_fire    = (r_in_state == IN_FILL) && S_VALID;
  assign w_m_fire    = (r_out_state == OUT_DRAIN) && M_READY;
  assign w_start     = (r_in_state == IN_FULL) && (r_out_state == OUT_IDLE);
  assign w_done_rise = DONE && !r_done_d;
  assign w_capt      = (r_out_state == OUT_CAPT);
  // DONE must stay high through capture cycle 6; the eighth DONE cycle aligns with capture cycle 6
  assign w_err_set   = (DONE && ((r_out_state == OUT_IDLE) || (r_out_state == OUT_DRAIN))) ||
                       (w_capt && !DONE && (r_ccnt != HW'(HALF - 1)));
  assign w_unused    = ^{w_ibuf_ser, w_obuf_p0, w_obuf_p1};
  assign ERR         = r_err;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_in_state  <= IN_FILL;
      r_out_state <= OUT_IDLE;
    end else begin
      r_in_state  <= w_in_next;
      r_out_state <= w_out_next;
    end
  end

  always_comb begin
    w_in_next = r_in_state;
    case (r_in_state)
      IN_FILL: if (w_s_fire && (r_icnt == CW'(N - 1))) w_in_next = IN_FULL;
      IN_FULL: if (w_start) w_in_next = IN_LOAD;
      IN_LOAD: if (r_lcnt == HW'(HALF - 1)) w_in_next = IN_FILL;
      default: w_in_next = IN_FILL;
    endcase
  end

  always_comb begin
    w_out_next = r_out_state;
    case (r_out_state)
      OUT_IDLE:  if (w_start) w_out_next = OUT_WAIT;
      OUT_WAIT:  if (w_done_rise) w_out_next = OUT_CAPT;
      OUT_CAPT:  if (r_ccnt == HW'(HALF - 1)) w_out_next = OUT_DRAIN;
      OUT_DRAIN: if (w_m_fire && (r_ocnt == CW'(N - 1))) w_out_next = OUT_IDLE;
      default:   w_out_next = OUT_IDLE;
    endcase
  end

  always_comb begin
    S_READY   = 1'b0;
    START     = 1'b0;
    LANE0_OUT = '0;
    LANE1_OUT = '0;
    M_VALID   = 1'b0;
    M_DATA    = '0;
    case (r_in_state)
      IN_FILL: S_READY = 1'b1;
      IN_FULL: START = (r_out_state == OUT_IDLE);
      IN_LOAD: begin
        LANE0_OUT = w_ld0;
        LANE1_OUT = w_ld1;
      end
      default: ;
    endcase
    if (r_out_state == OUT_DRAIN) begin
      M_VALID = 1'b1;
      M_DATA  = w_drain_data;
    end
  end

  // Counters wrap naturally, so each returns to 0 as its phase completes
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_icnt   <= '0;
      r_lcnt   <= '0;
      r_ccnt   <= '0;
      r_ocnt   <= '0;
      r_done_d <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done_d <= DONE;
      if (w_s_fire) r_icnt <= r_icnt + 1'b1;
      if (r_in_state == IN_LOAD) r_lcnt <= r_lcnt + 1'b1;
      if (w_capt) r_ccnt <= r_ccnt + 1'b1;
      if (w_m_fire) r_ocnt <= r_ocnt + 1'b1;
      if (w_err_set) r_err <= 1'b1;
    end
  end

  frame_buf #(.DW(DW), .SERIAL_WR(1'b1)) u_in_buf (
    .i_clk         (CLK),
    .i_we          (w_s_fire),
    .i_ser_idx     (r_icnt),
    .i_ser_wdata   (S_DATA),
    .o_ser_rdata   (w_ibuf_ser),
    .i_pair_idx    (r_lcnt),
    .i_pair_wdata0 ('0),
    .i_pair_wdata1 ('0),
    .o_pair_rdata0 (w_ld0),
    .o_pair_rdata1 (w_ld1)
  );

  frame_buf #(.DW(DW), .SERIAL_WR(1'b0)) u_out_buf (
    .i_clk         (CLK),
    .i_we          (w_capt),
    .i_ser_idx     (r_ocnt),
    .i_ser_wdata   ('0),
    .o_ser_rdata   (w_drain_data),
    .i_pair_idx    (r_ccnt),
    .i_pair_wdata0 (LANE0_IN),
    .i_pair_wdata1 (LANE1_IN),
    .o_pair_rdata0 (w_obuf_p0),
    .o_pair_rdata1 (w_obuf_p1)
  );

endmodule

// File: tb/tb_fft_stream_if.sv
// tb/tb_fft_stream_if.sv - scoreboard bench for fft_stream_if
module tb_fft_stream_if;

  localparam int DW = 16;
  typedef logic [2*DW-1:0] smp_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic S_VALID = 1'b0;
  logic S_READY;
  smp_t S_DATA = '0;
  logic START;
  smp_t LANE0_OUT, LANE1_OUT;
  logic DONE = 1'b0;
  smp_t LANE0_IN = '0;
  smp_t LANE1_IN = '0;
  logic M_VALID;
  logic M_READY = 1'b0;
  smp_t M_DATA;
  logic ERR;

  int checks = 0;
  int failures = 0;
  smp_t q_lane0[$];
  smp_t q_lane1[$];
  smp_t q_out[$];

  fft_stream_if #(.DW(DW), .N(16)) dut (
    .CLK(CLK), .RST(RST),
    .S_VALID(S_VALID), .S_READY(S_READY), .S_DATA(S_DATA),
    .START(START), .LANE0_OUT(LANE0_OUT), .LANE1_OUT(LANE1_OUT),
    .DONE(DONE), .LANE0_IN(LANE0_IN), .LANE1_IN(LANE1_IN),
    .M_VALID(M_VALID), .M_READY(M_READY), .M_DATA(M_DATA),
    .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RST = 1'b1; S_VALID = 1'b0; S_DATA = '0; DONE = 1'b0;
    LANE0_IN = '0; LANE1_IN = '0; M_READY = 1'b0;
    q_lane0.delete(); q_lane1.delete(); q_out.delete();
    repeat (2) tick();
    RST = 1'b0;
  endtask

  task automatic fill_frame(input smp_t base, input bit strict);
    for (int i = 0; i < 16; i++) begin
      int n = 0;
      while (S_READY !== 1'b1 && n < 200) begin tick(); n++; end
      if (S_READY !== 1'b1) begin
        checks++; failures++;
        $display("FAIL fill_timeout sample=%0d got_s_ready=%b exp=1", i, S_READY);
        S_VALID = 1'b0;
        return;
      end
      if (strict) begin
        checks++;
        if (n != 0) begin failures++; $display("FAIL fill_stall sample=%0d got_wait=%0d exp=0", i, n); end
      end
      S_VALID = 1'b1; S_DATA = base + smp_t'(i);
      tick();
    end
    S_VALID = 1'b0; S_DATA = '0;
    for (int k = 0; k < 8; k++) begin
      q_lane0.push_back(base + smp_t'(k));
      q_lane1.push_back(base + smp_t'(k + 8));
    end
  endtask

  task automatic expect_load();
    int n = 0;
    smp_t e0, e1;
    while (START !== 1'b1 && n < 200) begin tick(); n++; end
    checks++;
    if (START !== 1'b1) begin failures++; $display("FAIL load_start_timeout got=%b exp=1", START); return; end
    tick();
    for (int k = 0; k < 8; k++) begin
      e0 = q_lane0.pop_front();
      e1 = q_lane1.pop_front();
      checks++;
      if (LANE0_OUT !== e0 || LANE1_OUT !== e1) begin
        failures++;
        $display("FAIL load_lanes k=%0d got=%h,%h exp=%h,%h", k, LANE0_OUT, LANE1_OUT, e0, e1);
      end
      checks++;
      if (S_READY !== 1'b0 || START !== 1'b0) begin
        failures++;
        $display("FAIL load_ctrl k=%0d got_ready=%b got_start=%b exp=0,0", k, S_READY, START);
      end
      tick();
    end
    checks++;
    if (LANE0_OUT !== '0 || LANE1_OUT !== '0 || S_READY !== 1'b1) begin
      failures++;
      $display("FAIL load_end got=%h,%h ready=%b exp=0,0 ready=1", LANE0_OUT, LANE1_OUT, S_READY);
    end
  endtask

  task automatic capture(input smp_t base, input int nhigh);
    for (int s = 0; s < 16; s++) q_out.push_back(base + smp_t'(s));
    for (int t = 0; t <= 8; t++) begin
      if (t == 8) begin
        checks++;
        if (M_VALID !== 1'b0) begin failures++; $display("FAIL capt_early_valid got=%b exp=0", M_VALID); end
      end
      DONE = (t < nhigh);
      LANE0_IN = (t >= 1) ? base + smp_t'(t - 1) : '0;
      LANE1_IN = (t >= 1) ? base + smp_t'(t + 7) : '0;
      tick();
    end
    DONE = 1'b0; LANE0_IN = '0; LANE1_IN = '0;
  endtask

  task automatic drain(input bit stall, input bit feed, input smp_t feed_base);
    int c = 0;
    int fed = 0;
    bit rdy;
    bit prev_stall = 1'b0;
    smp_t prev_data = '0;
    smp_t junk;
    while (q_out.size() > 0 && c < 200) begin
      checks++;
      if (M_VALID !== 1'b1) begin
        failures++; $display("FAIL drain_valid cycle=%0d got=%b exp=1", c, M_VALID);
      end else begin
        checks++;
        if (M_DATA !== q_out[0]) begin
          failures++; $display("FAIL drain_data cycle=%0d got=%h exp=%h", c, M_DATA, q_out[0]);
        end
        if (prev_stall) begin
          checks++;
          if (M_DATA !== prev_data) begin
            failures++; $display("FAIL drain_hold cycle=%0d got=%h exp=%h", c, M_DATA, prev_data);
          end
        end
      end
      if (feed) begin
        checks++;
        if (START !== 1'b0) begin failures++; $display("FAIL overlap_early_start cycle=%0d got=%b exp=0", c, START); end
        if (fed < 16 && S_READY === 1'b1) begin
          S_VALID = 1'b1; S_DATA = feed_base + smp_t'(fed); fed++;
        end else begin
          S_VALID = 1'b0;
        end
      end
      rdy = stall ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
      M_READY = rdy;
      prev_stall = (M_VALID === 1'b1) && !rdy;
      prev_data = M_DATA;
      if (M_VALID === 1'b1 && rdy) junk = q_out.pop_front();
      tick();
      c++;
    end
    S_VALID = 1'b0; M_READY = 1'b0;
    checks++;
    if (q_out.size() != 0) begin failures++; $display("FAIL drain_timeout left=%0d exp=0", q_out.size()); end
    checks++;
    if (M_VALID !== 1'b0) begin failures++; $display("FAIL drain_end_valid got=%b exp=0", M_VALID); end
    if (!stall) begin
      checks++;
      if (c != 16) begin failures++; $display("FAIL drain_cycles got=%0d exp=16", c); end
    end
    if (feed) begin
      checks++;
      if (fed != 16) begin failures++; $display("FAIL overlap_fed got=%0d exp=16", fed); end
      checks++;
      if (START !== 1'b1) begin failures++; $display("FAIL overlap_start got=%b exp=1", START); end
      for (int k = 0; k < 8; k++) begin
        q_lane0.push_back(feed_base + smp_t'(k));
        q_lane1.push_back(feed_base + smp_t'(k + 8));
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (S_READY !== 1'b1 || START !== 1'b0 || M_VALID !== 1'b0 || ERR !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl got ready=%b start=%b mvalid=%b err=%b exp 1,0,0,0", S_READY, START, M_VALID, ERR);
    end
    checks++;
    if (LANE0_OUT !== '0 || LANE1_OUT !== '0) begin
      failures++; $display("FAIL reset_lanes got=%h,%h exp=0,0", LANE0_OUT, LANE1_OUT);
    end
    tick();
    checks++;
    if (S_READY !== 1'b1) begin failures++; $display("FAIL reset_release_ready got=%b exp=1", S_READY); end
  endtask

  task automatic test_fill_load();
    fill_frame(32'h0, 1'b1);
    checks++;
    if (START !== 1'b1) begin failures++; $display("FAIL fill_start_latency got=%b exp=1", START); end
    expect_load();
  endtask

  task automatic test_capture_drain();
    capture(32'h0, 8);
    drain(1'b0, 1'b0, '0);
    checks++;
    if (ERR !== 1'b0) begin failures++; $display("FAIL capture_err got=%b exp=0", ERR); end
  endtask

  task automatic test_backpressure();
    fill_frame(32'h0010_0100, 1'b0);
    expect_load();
    capture(32'h00A0_0A00, 8);
    drain(1'b1, 1'b0, '0);
  endtask

  task automatic test_back_to_back();
    do_reset();
    fill_frame(32'h1111_0000, 1'b0);
    expect_load();
    capture(32'hC1C1_0000, 8);
    drain(1'b1, 1'b1, 32'h2222_0000);
    expect_load();
    capture(32'hC2C2_0000, 8);
    drain(1'b0, 1'b0, '0);
    checks++;
    if (ERR !== 1'b0) begin failures++; $display("FAIL b2b_err got=%b exp=0", ERR); end
  endtask

  task automatic test_err_idle();
    do_reset();
    DONE = 1'b1; tick(); DONE = 1'b0;
    checks++;
    if (ERR !== 1'b1) begin failures++; $display("FAIL err_idle_set got=%b exp=1", ERR); end
    repeat (5) tick();
    checks++;
    if (ERR !== 1'b1) begin failures++; $display("FAIL err_idle_sticky got=%b exp=1", ERR); end
    do_reset();
    checks++;
    if (ERR !== 1'b0) begin failures++; $display("FAIL err_idle_clear got=%b exp=0", ERR); end
  endtask

  task automatic test_err_short();
    do_reset();
    fill_frame(32'h0050_0000, 1'b0);
    expect_load();
    capture(32'h0055_0000, 5);
    checks++;
    if (ERR !== 1'b1) begin failures++; $display("FAIL err_short_set got=%b exp=1", ERR); end
    drain(1'b0, 1'b0, '0);
    checks++;
    if (ERR !== 1'b1) begin failures++; $display("FAIL err_short_sticky got=%b exp=1", ERR); end
    do_reset();
    checks++;
    if (ERR !== 1'b0) begin failures++; $display("FAIL err_short_clear got=%b exp=0", ERR); end
  endtask

  task automatic test_mid_reset();
    int n = 0;
    int bad = 0;
    do_reset();
    fill_frame(32'h0003_0000, 1'b0);
    while (START !== 1'b1 && n < 200) begin tick(); n++; end
    checks++;
    if (START !== 1'b1) begin failures++; $display("FAIL midrst_start got=%b exp=1", START); end
    repeat (4) tick();
    checks++;
    if (LANE0_OUT !== 32'h0003_0003 || LANE1_OUT !== 32'h0003_000B) begin
      failures++; $display("FAIL midrst_k3 got=%h,%h exp=00030003,0003000b", LANE0_OUT, LANE1_OUT);
    end
    RST = 1'b1; tick(); RST = 1'b0;
    q_lane0.delete(); q_lane1.delete();
    checks++;
    if (START !== 1'b0 || S_READY !== 1'b1) begin
      failures++; $display("FAIL midrst_ctrl got start=%b ready=%b exp 0,1", START, S_READY);
    end
    checks++;
    if (LANE0_OUT !== '0 || LANE1_OUT !== '0) begin
      failures++; $display("FAIL midrst_lanes got=%h,%h exp=0,0", LANE0_OUT, LANE1_OUT);
    end
    repeat (20) begin
      if (M_VALID !== 1'b0 || START !== 1'b0) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL midrst_quiet got=%0d busy cycles exp=0", bad); end
  endtask

  initial begin
    test_reset();
    test_fill_load();
    test_capture_drain();
    test_backpressure();
    test_back_to_back();
    test_err_idle();
    test_err_short();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fft_stream_if.md
FFT_STREAM_IF -- requirements
Module: fft_stream_if

Interface
REQ-001 Parameter DW, default 16, is the bit width of each real and imaginary part; a sample is 2*DW bits, {re, im}.
REQ-002 Parameter N, default 16, is the frame length in samples and is fixed at 16 (8 lane-pairs).
REQ-003 CLK  in  1  sole clock; all logic on the rising edge.
REQ-004 RST  in  1  reset, synchronous and active-high.
REQ-005 S_VALID  in  1  upstream sample valid.
REQ-006 S_READY  out  1  block accepts a sample this cycle.
REQ-007 S_DATA  in  2*DW  upstream sample, natural order x[0]..x[15].
REQ-008 START  out  1  one-cycle frame-start pulse to the FFT controller.
REQ-009 LANE0_OUT, LANE1_OUT  out  2*DW each  sample pair to the datapath during load.
REQ-010 DONE  in  1  controller output-phase flag, high for exactly 8 cycles.
REQ-011 LANE0_IN, LANE1_IN  in  2*DW each  result pair from the I/O buffer, valid one cycle after each DONE cycle.
REQ-012 M_VALID  out  1  downstream result valid.
REQ-013 M_READY  in  1  downstream accepts.
REQ-014 M_DATA  out  2*DW  result sample, slot order 0..15.
REQ-015 ERR  out  1  sticky protocol-error flag.

Function
REQ-016 The input FSM SHALL have states IN_FILL, IN_FULL and IN_LOAD.
REQ-017 In IN_FILL, S_READY SHALL be 1; each S_VALID&S_READY cycle SHALL write S_DATA to input slot icnt and increment icnt; at icnt=15 the FSM SHALL go to IN_FULL.
REQ-018 In IN_FULL and IN_LOAD, S_READY SHALL be 0.
REQ-019 In IN_FULL, when the output FSM is in OUT_IDLE, START SHALL pulse high for one cycle and the FSM SHALL go to IN_LOAD on the next edge.
REQ-020 In IN_LOAD cycle k (k=0..7, starting the cycle after START), LANE0_OUT SHALL equal x[k] and LANE1_OUT SHALL equal x[k+8]; outside IN_LOAD both lane outputs SHALL be 0.
REQ-021 After k=7, the FSM SHALL return to IN_FILL with icnt=0, so the next frame fills while the current frame is in flight.
REQ-022 The output FSM SHALL have states OUT_IDLE, OUT_WAIT, OUT_CAPT and OUT_DRAIN; START SHALL move it from OUT_IDLE to OUT_WAIT.
REQ-023 In OUT_WAIT, a DONE rising edge SHALL begin capture; in OUT_CAPT capture cycle j (j=0..7, one cycle after DONE cycle j), LANE0_IN SHALL be stored to output slot j and LANE1_IN to slot j+8.
REQ-024 After j=7, the FSM SHALL enter OUT_DRAIN; M_VALID SHALL rise 9 cycles after the DONE rising edge.
REQ-025 In OUT_DRAIN, M_DATA SHALL present slot ocnt; ocnt SHALL increment on M_VALID&M_READY; M_DATA and M_VALID SHALL remain stable while M_VALID&!M_READY.
REQ-026 After slot 15 is accepted, M_VALID SHALL fall and the FSM SHALL return to OUT_IDLE in the same edge; a START pulse SHALL be allowed one cycle later.
REQ-027 ERR SHALL set if DONE is high in OUT_IDLE or OUT_DRAIN, or if DONE falls before 8 cycles in OUT_CAPT; in the short-DONE case, capture SHALL still run the full 8 cycles.

Reset
REQ-028 On RST, the following SHALL be 0 on the next edge: both FSMs to IN_FILL/OUT_IDLE, icnt, ocnt, capture count, START, M_VALID, ERR, and the lane outputs.
REQ-029 S_READY SHALL be 1 in the first cycle after reset is released.
REQ-030 Reset mid-frame SHALL discard both buffers' contents logically; buffer data need not be cleared.

Structure
REQ-031 Package fft_stream_pkg SHALL hold DW, N, the half-frame constant 8, and the enumerations of both FSMs.
REQ-032 Sub-module frame_buf SHALL be a 16 x 2*DW register file with one serial port and one pair port (slots j and j+8), with port direction set by parameter; it SHALL be instantiated twice, once for input and once for output.

Verification
REQ-033 Scenario: stream x[i]=i back-to-back with no DONE -> START 1 cycle after the 16th accept; load lanes (0,8),(1,9)..(7,15).
REQ-034 Scenario: drive DONE for 8 cycles with LANE0_IN=j and LANE1_IN=j+8 (j = capture cycle) and M_READY=1 -> M_DATA 0..15 on consecutive cycles, first at DONE rise+9.
REQ-035 Scenario: M_READY toggles 1,0,0,1 during drain -> no slot skipped or repeated; M_DATA stable while stalled.
REQ-036 Scenario: fill frame 2 during drain of frame 1 -> START for frame 2 occurs only after slot 15 of frame 1 is accepted.
REQ-037 Scenario: DONE pulsed in OUT_IDLE, and separately DONE held 5 cycles -> ERR=1 and held until RST.
REQ-038 Scenario: RST asserted during IN_LOAD k=3 -> next cycle START=0, lanes=0, S_READY=1, no M_VALID afterward.
